// File: rtl/fb_pixel_writer.sv
// ---------------------------------------------------------------------------
// fb_pixel_writer
//
// Purpose:
//   Sink for the line drawer's pixel stream. Each accepted point is clipped
//   against the visible screen. A point inside the screen becomes a single
//   framebuffer write on the cycle after it is accepted. A clear sequencer
//   sweeps the whole framebuffer with CLEAR_COLOR, one address per cycle.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   pix_valid   point on pix_x / pix_y / pix_color is valid
//   pix_ready   point can be accepted this cycle (combinational)
//   pix_x       signed X coordinate (32 bit)
//   pix_y       signed Y coordinate (32 bit)
//   pix_color   colour of the point
//   clear_req   start a full-screen clear (sampled while idle)
//   fb_we       framebuffer write strobe (registered)
//   fb_addr     framebuffer write address (registered)
//   fb_wdata    framebuffer write data (registered)
//   busy        high while a clear sweep is in progress
//   clear_done  one-cycle pulse after the last clear write
//   plot_count  points written, saturating at 0xFFFF
//   clip_count  points discarded by clipping, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module fb_pixel_writer #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int ADDR_W      = 19,
  parameter int COLOR_W     = 3,
  parameter int CLEAR_COLOR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [31:0]        pix_x,
  input  logic [31:0]        pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               clear_req,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  output logic               busy,
  output logic               clear_done,
  output logic [15:0]        plot_count,
  output logic [15:0]        clip_count
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic [31:0]         H_RES_W   = 32'(H_RES);
  localparam logic [31:0]         V_RES_W   = 32'(V_RES);
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [COLOR_W-1:0]  CLR_COLOR = COLOR_W'(CLEAR_COLOR);

  // Saturating increment for the 16-bit statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  // Signed window test 0 <= c < lim.
  function automatic logic in_window(input logic [31:0] c, input logic [31:0] lim);
    return ($signed(c) >= 32'sd0) && ($signed(c) < $signed(lim));
  endfunction

  // Linear address y*H_RES + x, formed at 64 bits and then truncated. Only
  // used for clipped coordinates, so the operands are non-negative.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [31:0] x, input logic [31:0] y);
    return ADDR_W'(({32'd0, y} * {32'd0, H_RES_W}) + {32'd0, x});
  endfunction

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    clr_addr_q, clr_addr_d;
  logic                 fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]    fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0]   fb_wdata_q, fb_wdata_d;
  logic                 busy_q, busy_d;
  logic                 clear_done_q, clear_done_d;
  logic [15:0]          plot_count_q, plot_count_d;
  logic [15:0]          clip_count_q, clip_count_d;

  logic                 xfer_s;
  logic                 inside_s;
  logic                 clr_last_s;

  // A pending clear request blocks the stream so it wins over a point.
  assign pix_ready  = (state_q == ST_IDLE) && !clear_req;
  assign xfer_s     = pix_valid && pix_ready;
  assign inside_s   = in_window(pix_x, H_RES_W) && in_window(pix_y, V_RES_W);
  // clr_addr_q tracks the address currently presented on fb_addr.
  assign clr_last_s = (clr_addr_q == LAST_ADDR);

  // State register and all registered outputs / counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clr_addr_q   <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
      plot_count_q <= 16'd0;
      clip_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      busy_q       <= busy_d;
      clear_done_q <= clear_done_d;
      plot_count_q <= plot_count_d;
      clip_count_q <= clip_count_d;
    end
  end

  // Next-state logic: idle until a clear is requested, sweep until the last address.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values of the write port, status flags and counters.
  always_comb begin
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    busy_d       = 1'b0;
    clear_done_d = 1'b0;
    clr_addr_d   = clr_addr_q;
    plot_count_d = plot_count_q;
    clip_count_d = clip_count_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          // The entry edge already loads address 0, so the sweep's first
          // write lines up with the first busy cycle.
          fb_we_d    = 1'b1;
          fb_addr_d  = '0;
          fb_wdata_d = CLR_COLOR;
          busy_d     = 1'b1;
          clr_addr_d = '0;
        end else if (xfer_s) begin
          if (inside_s) begin
            fb_we_d      = 1'b1;
            fb_addr_d    = lin_addr(pix_x, pix_y);
            fb_wdata_d   = pix_color;
            plot_count_d = sat_inc16(plot_count_q);
          end else begin
            clip_count_d = sat_inc16(clip_count_q);
          end
        end else begin
          fb_we_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (clr_last_s) begin
          clear_done_d = 1'b1;
          clr_addr_d   = '0;
        end else begin
          fb_we_d    = 1'b1;
          fb_addr_d  = clr_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          fb_wdata_d = CLR_COLOR;
          busy_d     = 1'b1;
          clr_addr_d = clr_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        fb_we_d = 1'b0;
      end
    endcase
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign busy       = busy_q;
  assign clear_done = clear_done_q;
  assign plot_count = plot_count_q;
  assign clip_count = clip_count_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// ---------------------------------------------------------------------------
// tb_fb_pixel_writer
//
// Two instances: a 640x480 one for point writes and clipping, and an 8x4
// one (CLEAR_COLOR=5) so clear sweeps stay short. Expected values come from
// a reference model that works on plain integer coordinates.
// ---------------------------------------------------------------------------
module tb_fb_pixel_writer;

  localparam int BH = 640;
  localparam int BV = 480;
  localparam int SH = 8;
  localparam int SV = 4;
  localparam int AW = 19;
  localparam int CW = 3;
  localparam int S_CLR = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 640x480 instance signals
  logic          rst_b_n;
  logic          b_valid, b_ready, b_clear, b_we, b_busy, b_done;
  logic [31:0]   b_x, b_y;
  logic [CW-1:0] b_color, b_wdata;
  logic [AW-1:0] b_addr;
  logic [15:0]   b_plot, b_clip;

  // 8x4 instance signals
  logic          rst_s_n;
  logic          s_valid, s_ready, s_clear, s_we, s_busy, s_done;
  logic [31:0]   s_x, s_y;
  logic [CW-1:0] s_color, s_wdata;
  logic [AW-1:0] s_addr;
  logic [15:0]   s_plot, s_clip;

  fb_pixel_writer #(.H_RES(BH), .V_RES(BV), .ADDR_W(AW), .COLOR_W(CW), .CLEAR_COLOR(0)) u_big (
    .clk(clk), .rst_n(rst_b_n), .pix_valid(b_valid), .pix_ready(b_ready),
    .pix_x(b_x), .pix_y(b_y), .pix_color(b_color), .clear_req(b_clear),
    .fb_we(b_we), .fb_addr(b_addr), .fb_wdata(b_wdata), .busy(b_busy),
    .clear_done(b_done), .plot_count(b_plot), .clip_count(b_clip)
  );

  fb_pixel_writer #(.H_RES(SH), .V_RES(SV), .ADDR_W(AW), .COLOR_W(CW), .CLEAR_COLOR(S_CLR)) u_small (
    .clk(clk), .rst_n(rst_s_n), .pix_valid(s_valid), .pix_ready(s_ready),
    .pix_x(s_x), .pix_y(s_y), .pix_color(s_color), .clear_req(s_clear),
    .fb_we(s_we), .fb_addr(s_addr), .fb_wdata(s_wdata), .busy(s_busy),
    .clear_done(s_done), .plot_count(s_plot), .clip_count(s_clip)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int            exp_plot_b = 0, exp_clip_b = 0;
  int            exp_plot_s = 0, exp_clip_s = 0;
  logic [AW-1:0] last_addr_b = '0;
  logic [CW-1:0] last_data_b = '0;

  function automatic bit ref_inside(int x, int y, int h, int v);
    return (x >= 0) && (x < h) && (y >= 0) && (y < v);
  endfunction

  function automatic logic [AW-1:0] ref_addr(int x, int y, int h);
    longint a;
    a = longint'(y) * longint'(h) + longint'(x);
    return AW'(a % (longint'(1) << AW));
  endfunction

  function automatic int sat16(int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic int rand_coord(int lim);
    int r;
    case ($urandom_range(0, 3))
      0:       r = int'($urandom_range(0, lim - 1));
      1:       r = int'($urandom_range(0, lim + 80)) - 40;
      2:       r = int'($urandom());
      default: begin
        case ($urandom_range(0, 3))
          0:       r = -1;
          1:       r = 0;
          2:       r = lim - 1;
          default: r = lim;
        endcase
      end
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_b_n = 1'b0; rst_s_n = 1'b0;
    b_valid = 1'b0; b_clear = 1'b0; b_x = '0; b_y = '0; b_color = '0;
    s_valid = 1'b0; s_clear = 1'b0; s_x = '0; s_y = '0; s_color = '0;
    repeat (3) tick();
    total++;
    if ({b_we, b_addr, b_wdata, b_busy, b_done, b_plot, b_clip} !== '0) begin
      bad++; $display("FAIL reset_big: got %h want 0", {b_we, b_addr, b_wdata, b_busy, b_done, b_plot, b_clip});
    end
    total++;
    if ({s_we, s_addr, s_wdata, s_busy, s_done, s_plot, s_clip} !== '0) begin
      bad++; $display("FAIL reset_small: got %h want 0", {s_we, s_addr, s_wdata, s_busy, s_done, s_plot, s_clip});
    end
    rst_b_n = 1'b1; rst_s_n = 1'b1;
    tick();
    total++;
    if ({b_ready, s_ready, b_we, s_we, b_busy, s_busy} !== 6'b110000) begin
      bad++; $display("FAIL reset_idle: got %b want 110000", {b_ready, s_ready, b_we, s_we, b_busy, s_busy});
    end
  endtask

  task automatic test_single_point();
    b_valid = 1'b1; b_x = 32'd5; b_y = 32'd2; b_color = 3'd3;
    #1;
    total++;
    if (b_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", b_ready); end
    tick();
    b_valid = 1'b0;
    exp_plot_b = sat16(exp_plot_b + 1);
    last_addr_b = ref_addr(5, 2, BH); last_data_b = 3'd3;
    total++;
    if ({b_we, b_addr, b_wdata} !== {1'b1, last_addr_b, last_data_b}) begin
      bad++; $display("FAIL single_write: got we=%b addr=%0d data=%0d want we=1 addr=%0d data=%0d", b_we, b_addr, b_wdata, last_addr_b, last_data_b);
    end
    total++;
    if (b_plot !== 16'(exp_plot_b)) begin bad++; $display("FAIL single_plot: got %0d want %0d", b_plot, exp_plot_b); end
    tick();
    total++;
    if ({b_we, b_addr} !== {1'b0, last_addr_b}) begin
      bad++; $display("FAIL single_after: got we=%b addr=%0d want we=0 addr=%0d", b_we, b_addr, last_addr_b);
    end
  endtask

  task automatic test_stream();
    int xs[4] = '{0, 639, -1, 640};
    int ys[4] = '{0, 479, 10, 0};
    logic [CW-1:0] c;
    logic exp_we;
    for (int i = 0; i < 4; i++) begin
      c = CW'($urandom_range(0, 7));
      b_valid = 1'b1; b_x = xs[i]; b_y = ys[i]; b_color = c;
      #1;
      total++;
      if (b_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d]: got %b want 1", i, b_ready); end
      tick();
      if (ref_inside(xs[i], ys[i], BH, BV)) begin
        exp_plot_b = sat16(exp_plot_b + 1);
        last_addr_b = ref_addr(xs[i], ys[i], BH); last_data_b = c; exp_we = 1'b1;
      end else begin
        exp_clip_b = sat16(exp_clip_b + 1); exp_we = 1'b0;
      end
      total++;
      if ({b_we, b_addr, b_wdata} !== {exp_we, last_addr_b, last_data_b}) begin
        bad++; $display("FAIL stream_write[%0d]: got we=%b addr=%0d data=%0d want we=%b addr=%0d data=%0d", i, b_we, b_addr, b_wdata, exp_we, last_addr_b, last_data_b);
      end
    end
    b_valid = 1'b0;
    tick();
    total++;
    if ({b_we, b_plot, b_clip} !== {1'b0, 16'(exp_plot_b), 16'(exp_clip_b)}) begin
      bad++; $display("FAIL stream_counts: got we=%b plot=%0d clip=%0d want we=0 plot=%0d clip=%0d", b_we, b_plot, b_clip, exp_plot_b, exp_clip_b);
    end
  endtask

  task automatic test_random();
    int x, y;
    bit v;
    logic [CW-1:0] c;
    logic exp_we;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 9) < 7);
      x = rand_coord(BH); y = rand_coord(BV);
      c = CW'($urandom_range(0, 7));
      b_valid = v; b_x = x; b_y = y; b_color = c;
      #1;
      total++;
      if (b_ready !== 1'b1) begin bad++; $display("FAIL rand_ready[%0d]: got %b want 1", i, b_ready); end
      tick();
      exp_we = 1'b0;
      if (v) begin
        if (ref_inside(x, y, BH, BV)) begin
          exp_plot_b = sat16(exp_plot_b + 1);
          last_addr_b = ref_addr(x, y, BH); last_data_b = c; exp_we = 1'b1;
        end else begin
          exp_clip_b = sat16(exp_clip_b + 1);
        end
      end
      total++;
      if ({b_we, b_addr, b_wdata} !== {exp_we, last_addr_b, last_data_b}) begin
        bad++; $display("FAIL rand_write[%0d]: x=%0d y=%0d got we=%b addr=%0d data=%0d want we=%b addr=%0d data=%0d", i, x, y, b_we, b_addr, b_wdata, exp_we, last_addr_b, last_data_b);
      end
    end
    b_valid = 1'b0;
    tick();
    total++;
    if ({b_plot, b_clip} !== {16'(exp_plot_b), 16'(exp_clip_b)}) begin
      bad++; $display("FAIL rand_counts: got plot=%0d clip=%0d want plot=%0d clip=%0d", b_plot, b_clip, exp_plot_b, exp_clip_b);
    end
  endtask

  task automatic test_clear();
    s_clear = 1'b1; s_valid = 1'b0;
    #1;
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL clear_ready_req: got %b want 0", s_ready); end
    tick();
    s_clear = 1'b0;
    for (int k = 0; k < SH * SV; k++) begin
      total++;
      if ({s_busy, s_we, s_addr, s_wdata, s_done, s_ready} !== {1'b1, 1'b1, AW'(k), CW'(S_CLR), 1'b0, 1'b0}) begin
        bad++; $display("FAIL clear_sweep[%0d]: got busy=%b we=%b addr=%0d data=%0d done=%b ready=%b want 1 1 %0d %0d 0 0", k, s_busy, s_we, s_addr, s_wdata, s_done, s_ready, k, S_CLR);
      end
      tick();
    end
    total++;
    if ({s_done, s_busy, s_we, s_ready} !== 4'b1001) begin
      bad++; $display("FAIL clear_done: got done/busy/we/ready=%b want 1001", {s_done, s_busy, s_we, s_ready});
    end
    tick();
    total++;
    if ({s_done, s_plot, s_clip} !== {1'b0, 16'(exp_plot_s), 16'(exp_clip_s)}) begin
      bad++; $display("FAIL clear_after: got done=%b plot=%0d clip=%0d want 0 %0d %0d", s_done, s_plot, s_clip, exp_plot_s, exp_clip_s);
    end
  endtask

  task automatic test_clear_vs_point();
    s_clear = 1'b1; s_valid = 1'b1; s_x = 32'd3; s_y = 32'd1; s_color = 3'd2;
    #1;
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL cvp_ready_req: got %b want 0", s_ready); end
    tick();
    s_clear = 1'b0;
    for (int k = 0; k < SH * SV; k++) begin
      total++;
      if ({s_ready, s_we, s_addr} !== {1'b0, 1'b1, AW'(k)}) begin
        bad++; $display("FAIL cvp_sweep[%0d]: got ready=%b we=%b addr=%0d want 0 1 %0d", k, s_ready, s_we, s_addr, k);
      end
      tick();
    end
    total++;
    if ({s_done, s_ready} !== 2'b11) begin bad++; $display("FAIL cvp_done: got done/ready=%b want 11", {s_done, s_ready}); end
    tick();
    s_valid = 1'b0;
    exp_plot_s = sat16(exp_plot_s + 1);
    total++;
    if ({s_we, s_addr, s_wdata, s_plot} !== {1'b1, ref_addr(3, 1, SH), 3'd2, 16'(exp_plot_s)}) begin
      bad++; $display("FAIL cvp_write: got we=%b addr=%0d data=%0d plot=%0d want 1 %0d 2 %0d", s_we, s_addr, s_wdata, s_plot, ref_addr(3, 1, SH), exp_plot_s);
    end
    tick();
    total++;
    if (s_we !== 1'b0) begin bad++; $display("FAIL cvp_idle: got we=%b want 0", s_we); end
  endtask

  task automatic test_back_to_back();
    s_clear = 1'b1; s_valid = 1'b0;
    tick();
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < SH * SV; k++) begin
        total++;
        if ({s_busy, s_we, s_addr, s_done} !== {1'b1, 1'b1, AW'(k), 1'b0}) begin
          bad++; $display("FAIL b2b_sweep[%0d][%0d]: got busy=%b we=%b addr=%0d done=%b want 1 1 %0d 0", pass, k, s_busy, s_we, s_addr, s_done, k);
        end
        tick();
      end
      // clear_req still high during the first done cycle keeps the stream blocked
      total++;
      if ({s_done, s_busy, s_we, s_ready} !== {1'b1, 1'b0, 1'b0, (pass == 1)}) begin
        bad++; $display("FAIL b2b_done[%0d]: got done/busy/we/ready=%b", pass, {s_done, s_busy, s_we, s_ready});
      end
      tick();
      s_clear = 1'b0;
    end
    total++;
    if ({s_done, s_busy, s_we} !== 3'b000) begin bad++; $display("FAIL b2b_end: got %b want 000", {s_done, s_busy, s_we}); end
  endtask

  task automatic test_reset_mid_clear();
    bit seen;
    s_clear = 1'b1; s_valid = 1'b0;
    tick();
    s_clear = 1'b0;
    repeat (10) tick();
    total++;
    if ({s_busy, s_we, s_addr} !== {1'b1, 1'b1, AW'(10)}) begin
      bad++; $display("FAIL midrst_pre: got busy=%b we=%b addr=%0d want 1 1 10", s_busy, s_we, s_addr);
    end
    #2 rst_s_n = 1'b0;
    #1;
    total++;
    if ({s_we, s_busy, s_done, s_plot, s_clip} !== '0) begin
      bad++; $display("FAIL midrst_async: got we=%b busy=%b done=%b plot=%0d clip=%0d want all 0", s_we, s_busy, s_done, s_plot, s_clip);
    end
    #1 rst_s_n = 1'b1;
    exp_plot_s = 0; exp_clip_s = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_done || s_busy || s_we || !s_ready) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL midrst_after: got activity=%b want 0", seen); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 65535; i++) begin
      s_valid = 1'b1; s_x = 32'($urandom_range(0, SH - 1)); s_y = 32'($urandom_range(0, SV - 1));
      s_color = CW'($urandom_range(0, 7));
      exp_plot_s = sat16(exp_plot_s + 1);
      tick();
    end
    s_valid = 1'b0;
    tick();
    total++;
    if (s_plot !== 16'(exp_plot_s)) begin bad++; $display("FAIL sat_reach: got %0d want %0d", s_plot, exp_plot_s); end
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_x = 32'd7; s_y = 32'd3; s_color = 3'd6;
      exp_plot_s = sat16(exp_plot_s + 1);
      tick();
    end
    s_valid = 1'b0;
    total++;
    if ({s_we, s_addr, s_wdata} !== {1'b1, ref_addr(7, 3, SH), 3'd6}) begin
      bad++; $display("FAIL sat_write: got we=%b addr=%0d data=%0d want 1 %0d 6", s_we, s_addr, s_wdata, ref_addr(7, 3, SH));
    end
    tick();
    total++;
    if ({s_plot, s_clip} !== {16'(exp_plot_s), 16'(exp_clip_s)}) begin
      bad++; $display("FAIL sat_hold: got plot=%0d clip=%0d want %0d %0d", s_plot, s_clip, exp_plot_s, exp_clip_s);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_point();
    test_stream();
    test_random();
    test_clear();
    test_clear_vs_point();
    test_back_to_back();
    test_reset_mid_clear();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
